apb_bridge_param: RTL and testbench

APB_BRIDGE_PARAM -- requirements
Module: apb_bridge_param

---
 rtl/apb_bridge_param.sv | 235 +++++++++++++++++++++++
 tb/tb_apb_bridge_param.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_param.sv
// AHB-Lite to APB bridge with a parameterised number of APB slaves.
// One AHB transfer at a time: address decode selects a slave window,
// decode failures, slave errors and stuck slaves return a two-cycle
// AHB ERROR response, and every output is driven from a register.
//
// Handshake summary:
//   AHB side: a transfer is accepted only while idle (hreadyout=1) and
//   hsel & htrans[1] & hready are all high. hreadyout stays low until
//   the transfer completes. Errors hold hresp high for two cycles, with
//   hreadyout low then high.
//   APB side: psel rises for one SETUP cycle, then penable rises with
//   psel, paddr, pwrite and pwdata frozen. The access ends on the first
//   ACCESS cycle in which the selected slave drives pready high. Only
//   the selected slave's pready/pslverr/prdata are ever looked at.
module apb_bridge_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   hsel,
    input  logic                   hwrite,
    input  logic                   hready,
    input  logic [1:0]             htrans,
    input  logic [ADDR_W-1:0]      haddr,
    input  logic [DATA_W-1:0]      hwdata,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [DATA_W-1:0]      hrdata,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDR_W-1:0]      paddr,
    output logic [DATA_W-1:0]      pwdata,
    input  logic [NSLV*DATA_W-1:0] prdata,
    input  logic [NSLV-1:0]        pready,
    input  logic [NSLV-1:0]        pslverr,
    output logic [2:0]             dbg_state_o
);

    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int TOW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [IDXW-1:0]     idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   hrdata_q;
    logic [NSLV-1:0]     psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                hreadyout_q;
    logic                hresp_q;
    logic [TOW-1:0]      tcnt_q;

    // Address-phase decode, valid only while the FSM is idle.
    logic                hvalid;
    logic [IDXW-1:0]     dec_idx_d;
    logic [ADDR_W-1:0]   dec_upper_d;
    logic                dec_oob_d;
    logic                dec_err_d;
    logic [NSLV-1:0]     dec_sel_d;

    // Selected-slave view of the APB return signals.
    logic [DATA_W-1:0]   sel_rdata_d;
    logic                sel_ready_d;
    logic                sel_err_d;
    logic [NSLV-1:0]     held_sel_d;
    logic                to_hit_d;

    assign hvalid      = hsel & htrans[1] & hready;
    assign dec_idx_d   = haddr[SLV_AW +: IDXW];
    assign dec_upper_d = haddr >> (SLV_AW + IDXW);

    // An index past the last slave can only occur when NSLV is not a power of two.
    generate
        if ((1 << IDXW) > NSLV) begin : g_oob
            assign dec_oob_d = ({{(32-IDXW){1'b0}}, dec_idx_d} >= 32'(NSLV));
        end else begin : g_no_oob
            assign dec_oob_d = 1'b0;
        end
    endgenerate

    assign dec_err_d = dec_oob_d | (dec_upper_d != '0);

    // The TIMEOUT-th consecutive low cycle is the one seen with the counter at TIMEOUT-1.
    assign to_hit_d = (TIMEOUT != 0) &&
                      ({{(32-TOW){1'b0}}, tcnt_q} == 32'(TIMEOUT - 1));

    // One-hot slave selects for the incoming address and for the held index.
    always_comb begin
        dec_sel_d  = '0;
        held_sel_d = '0;
        for (int k = 0; k < NSLV; k++) begin
            dec_sel_d[k]  = (dec_idx_d == IDXW'(k));
            held_sel_d[k] = (idx_q == IDXW'(k));
        end
    end

    // Route the held slave's ready, error and read data.
    always_comb begin
        sel_rdata_d = '0;
        sel_ready_d = 1'b0;
        sel_err_d   = 1'b0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == IDXW'(k)) begin
                sel_rdata_d = prdata[k*DATA_W +: DATA_W];
                sel_ready_d = pready[k];
                sel_err_d   = pslverr[k];
            end
        end
    end

    // Bridge FSM; all bus outputs are registered alongside the state.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hvalid) begin
                        addr_q      <= haddr;
                        write_q     <= hwrite;
                        idx_q       <= dec_idx_d;
                        hreadyout_q <= 1'b0;
                        if (dec_err_d) begin
                            // Bad address: no APB cycle, data phase ignored.
                            state_q <= S_ERR1;
                            hresp_q <= 1'b1;
                        end else if (hwrite) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q  <= S_SETUP;
                            psel_q   <= dec_sel_d;
                            paddr_q  <= haddr;
                            pwrite_q <= 1'b0;
                        end
                    end
                end
                S_WDATA: begin
                    // hwdata belongs to the cycle after the address phase.
                    state_q  <= S_SETUP;
                    wdata_q  <= hwdata;
                    psel_q   <= held_sel_d;
                    paddr_q  <= addr_q;
                    pwrite_q <= write_q;
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                    tcnt_q    <= '0;
                end
                S_ACCESS: begin
                    if (sel_ready_d) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (sel_err_d) begin
                            state_q <= S_ERR1;
                            hresp_q <= 1'b1;
                        end else begin
                            state_q     <= S_IDLE;
                            hreadyout_q <= 1'b1;
                            if (!write_q) begin
                                hrdata_q <= sel_rdata_d;
                            end
                        end
                    end else if (to_hit_d) begin
                        // Slave held pready low too long: abandon it.
                        state_q   <= S_ERR1;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        hresp_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TOW'(1);
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                S_ERR2: begin
                    // Second error cycle; any address presented now is dropped.
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign hreadyout   = hreadyout_q;
    assign hresp       = hresp_q;
    assign hrdata      = hrdata_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_bridge_param.sv
// Bench for apb_bridge_param (NSLV=4, SLV_AW=12, TIMEOUT=8).
// Transactions are expanded into a per-cycle plan of inputs and expected
// outputs from the bridge's transfer rules; a driver plays the plan and a
// single compare process checks every cycle on the falling edge.
module tb_apb_bridge_param;

    localparam int TMO = 8;

    logic         hclk = 1'b0;
    logic         hreset;
    logic         hsel, hwrite, hready;
    logic [1:0]   htrans;
    logic [31:0]  haddr, hwdata;
    logic         hreadyout, hresp;
    logic [31:0]  hrdata;
    logic [3:0]   psel;
    logic         penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [127:0] prdata;
    logic [3:0]   pready, pslverr;
    logic [2:0]   dbg_state;

    apb_bridge_param #(
        .ADDR_W(32), .DATA_W(32), .NSLV(4), .SLV_AW(12), .TIMEOUT(TMO)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .hwrite(hwrite),
        .hready(hready), .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 hclk = ~hclk;

    typedef struct {
        logic         rst, hsel, hready, hwrite;
        logic [1:0]   htrans;
        logic [31:0]  haddr, hwdata;
        logic [3:0]   pready, pslverr;
        logic [127:0] prdata;
        bit           chk, chk_apb, chk_pwdata, chk_rst;
        logic         e_hreadyout, e_hresp, e_penable, e_pwrite;
        logic [3:0]   e_psel;
        logic [31:0]  e_paddr, e_pwdata, e_hrdata;
        int           tag;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        exp_q[$];
    cyc_t        ce;
    logic [31:0] last_rd = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Random bus activity with idle-bridge expectations.
    function automatic cyc_t noise();
        cyc_t c;
        c.rst = 1'b0;
        c.hsel = 1'($urandom_range(0, 1));
        c.hready = 1'($urandom_range(0, 1));
        c.hwrite = 1'($urandom_range(0, 1));
        c.htrans = 2'($urandom_range(0, 3));
        c.haddr = $urandom();
        c.hwdata = $urandom();
        c.pready = 4'($urandom_range(0, 15));
        c.pslverr = 4'($urandom_range(0, 15));
        c.prdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        c.chk = 1'b1; c.chk_apb = 1'b0; c.chk_pwdata = 1'b0; c.chk_rst = 1'b0;
        c.e_hreadyout = 1'b1; c.e_hresp = 1'b0; c.e_penable = 1'b0; c.e_pwrite = 1'b0;
        c.e_psel = 4'h0; c.e_paddr = 32'h0; c.e_pwdata = 32'h0;
        c.e_hrdata = last_rd;
        c.tag = 0;
        return c;
    endfunction

    // Idle cycle whose AHB inputs never form a valid transfer.
    function automatic cyc_t gap();
        cyc_t c;
        c = noise();
        case ($urandom_range(0, 2))
            0: c.hsel = 1'b0;
            1: c.htrans[1] = 1'b0;
            default: c.hready = 1'b0;
        endcase
        return c;
    endfunction

    function automatic cyc_t apb_exp(cyc_t c, int slave, logic [31:0] addr, bit wr,
                                     logic [31:0] wd, bit pen);
        c.e_hreadyout = 1'b0;
        c.e_psel = 4'(1 << slave);
        c.e_penable = pen;
        c.chk_apb = 1'b1;
        c.e_paddr = addr;
        c.e_pwrite = wr;
        c.chk_pwdata = wr;
        c.e_pwdata = wd;
        return c;
    endfunction

    task automatic add_gap();
        plan.push_back(gap());
    endtask

    task automatic add_err();
        cyc_t c;
        c = noise();
        c.e_hreadyout = 1'b0; c.e_hresp = 1'b1;
        plan.push_back(c);
        c = noise();
        c.e_hreadyout = 1'b1; c.e_hresp = 1'b1;
        c.hsel = 1'b1; c.htrans = 2'b10; c.hready = 1'b1;
        c.haddr = {18'h0, c.haddr[13:0]};
        plan.push_back(c);
    endtask

    // One AHB transfer: address phase, then whatever cycles the rules demand.
    task automatic add_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input int lows, input bit err, input logic [31:0] rd);
        cyc_t        c;
        logic [31:0] slave_no;
        int          slave;
        int          n_acc;
        bit          tmo;
        slave_no = addr / 32'd4096;
        c = noise();
        c.hsel = 1'b1; c.hready = 1'b1; c.hwrite = wr; c.haddr = addr;
        c.htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        plan.push_back(c);
        if (slave_no >= 32'd4) begin
            add_err();
            return;
        end
        slave = int'(slave_no);
        if (wr) begin
            c = noise();
            c.e_hreadyout = 1'b0;
            c.hwdata = wd;
            plan.push_back(c);
        end
        tmo = (lows >= TMO);
        n_acc = tmo ? TMO : lows + 1;
        c = noise();
        plan.push_back(apb_exp(c, slave, addr, wr, wd, 1'b0));
        for (int i = 0; i < n_acc; i++) begin
            c = apb_exp(noise(), slave, addr, wr, wd, 1'b1);
            c.pready[slave] = (i == lows);
            if (i == lows) begin
                c.pslverr[slave] = err;
                c.prdata[slave*32 +: 32] = rd;
            end
            plan.push_back(c);
        end
        if (tmo || err) add_err();
        else if (!wr) last_rd = rd;
    endtask

    // Read that is cut short by reset on its third ACCESS cycle.
    task automatic add_rst_access(input logic [31:0] addr);
        cyc_t c;
        int   slave;
        slave = int'(addr / 32'd4096);
        c = noise();
        c.hsel = 1'b1; c.hready = 1'b1; c.hwrite = 1'b0; c.haddr = addr; c.htrans = 2'b10;
        plan.push_back(c);
        plan.push_back(apb_exp(noise(), slave, addr, 1'b0, 32'h0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            c = apb_exp(noise(), slave, addr, 1'b0, 32'h0, 1'b1);
            c.pready[slave] = 1'b0;
            c.rst = (i == 2);
            plan.push_back(c);
        end
        last_rd = 32'h0;
        c = gap();
        c.chk_rst = 1'b1; c.tag = 7;
        plan.push_back(c);
    endtask

    function automatic int count_access(int from);
        int n = 0;
        for (int k = from; k < plan.size(); k++) if (plan[k].e_penable === 1'b1) n++;
        return n;
    endfunction

    task automatic drive(input cyc_t c);
        hreset = c.rst; hsel = c.hsel; hready = c.hready; hwrite = c.hwrite;
        htrans = c.htrans; haddr = c.haddr; hwdata = c.hwdata;
        pready = c.pready; pslverr = c.pslverr; prdata = c.prdata;
    endtask

    // Scoreboard: model expectations every cycle, plus literal pins on tagged cycles.
    always @(negedge hclk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            cyc_n++;
            if (ce.chk) begin
                check("hreadyout", hreadyout, ce.e_hreadyout);
                check("hresp", hresp, ce.e_hresp);
                check("psel", psel, ce.e_psel);
                check("penable", penable, ce.e_penable);
                check("hrdata", hrdata, ce.e_hrdata);
                check("psel_onehot0", $onehot0(psel), 1'b1);
                if (ce.chk_apb) begin
                    check("paddr", paddr, ce.e_paddr);
                    check("pwrite", pwrite, ce.e_pwrite);
                end
                if (ce.chk_pwdata) check("pwdata", pwdata, ce.e_pwdata);
                if (ce.chk_rst) begin
                    check("rst_paddr", paddr, 32'h0);
                    check("rst_pwrite", pwrite, 1'b0);
                    check("rst_pwdata", pwdata, 32'h0);
                end
                case (ce.tag)
                    1: begin
                        check("lit_rd_setup_psel", psel, 4'b0100);
                        check("lit_rd_setup_penable", penable, 1'b0);
                    end
                    2: check("lit_rd_access_penable", penable, 1'b1);
                    3: begin
                        check("lit_rd_done_hreadyout", hreadyout, 1'b1);
                        check("lit_rd_done_hrdata", hrdata, 32'hDEADBEEF);
                    end
                    4: begin
                        check("lit_wr_pwdata", pwdata, 32'h12345678);
                        check("lit_wr_hreadyout", hreadyout, 1'b0);
                    end
                    5: begin
                        check("lit_err1_hresp", hresp, 1'b1);
                        check("lit_err1_hreadyout", hreadyout, 1'b0);
                        check("lit_err1_psel", psel, 4'b0000);
                    end
                    6: begin
                        check("lit_err2_hresp", hresp, 1'b1);
                        check("lit_err2_hreadyout", hreadyout, 1'b1);
                    end
                    7: begin
                        check("lit_rst_psel", psel, 4'b0000);
                        check("lit_rst_penable", penable, 1'b0);
                        check("lit_rst_hreadyout", hreadyout, 1'b1);
                        check("lit_rst_hresp", hresp, 1'b0);
                        check("lit_rst_hrdata", hrdata, 32'h0);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Plan construction and driver
    initial begin
        cyc_t        c;
        int          i0;
        bit          wr, err;
        int          lows;
        logic [31:0] addr;

        hreset = 1'b1; hsel = 1'b0; hready = 1'b1; hwrite = 1'b0; htrans = 2'b00;
        haddr = '0; hwdata = '0; pready = '0; pslverr = '0; prdata = '0;

        // Reset
        c = gap(); c.rst = 1'b1; c.chk = 1'b0; plan.push_back(c);
        c = gap(); c.rst = 1'b1; c.chk_rst = 1'b1; c.tag = 7; plan.push_back(c);
        add_gap();

        // Zero-wait read from slave 2
        i0 = plan.size();
        add_xfer(1'b0, 32'h0000_2010, 32'h0, 0, 1'b0, 32'hDEADBEEF);
        plan[i0+1].tag = 1;
        plan[i0+2].tag = 2;
        add_gap();
        plan[plan.size()-1].tag = 3;
        check("model_rd_len", plan.size() - i0, 4);

        // Write with three wait cycles
        i0 = plan.size();
        add_xfer(1'b1, 32'h0000_1004, 32'h12345678, 3, 1'b0, 32'h0);
        for (int k = i0 + 3; k < i0 + 7; k++) plan[k].tag = 4;
        check("model_wr_access_cycles", count_access(i0), 4);

        // Slave error on read: hrdata must keep the earlier value
        i0 = plan.size();
        add_xfer(1'b0, 32'h0000_0040, 32'h0, 0, 1'b1, 32'hCAFEF00D);
        plan[i0+3].tag = 5;
        plan[i0+4].tag = 6;
        add_gap();
        plan[plan.size()-1].tag = 3;

        // Decode error
        i0 = plan.size();
        add_xfer(1'b0, 32'h0001_0000, 32'h0, 0, 1'b0, 32'h0);
        plan[i0+1].tag = 5;
        plan[i0+2].tag = 6;
        check("model_decode_err_len", plan.size() - i0, 3);

        // Window boundary: last word of slave 3, then first address past it
        add_xfer(1'b0, 32'h0000_3FFC, 32'h0, 1, 1'b0, 32'h0BADF00D);
        add_xfer(1'b1, 32'h0000_4000, 32'h55AA55AA, 0, 1'b0, 32'h0);

        // Stuck slave 3
        i0 = plan.size();
        add_xfer(1'b0, 32'h0000_3000, 32'h0, 20, 1'b0, 32'h0);
        plan[i0+10].tag = 5;
        plan[i0+11].tag = 6;
        check("model_timeout_access_cycles", count_access(i0), TMO);

        // Reset in the middle of an access
        add_rst_access(32'h0000_1008);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) add_gap();
            wr = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 9) == 0) addr = $urandom() | 32'h0000_4000;
            else addr = {18'h0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095))};
            lows = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 10) : $urandom_range(0, 3);
            err = ($urandom_range(0, 5) == 0);
            add_xfer(wr, addr, $urandom(), lows, err, $urandom());
        end
        add_gap();
        add_gap();

        foreach (plan[k]) begin
            @(posedge hclk);
            #1;
            drive(plan[k]);
            exp_q.push_back(plan[k]);
        end
        @(posedge hclk);
        @(negedge hclk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
